// File: rtl/opstage_pkg.sv
// Shared types and helpers for the operand-resolve stage: address-width function,
// default register-address width and the bypass-source record.
package opstage_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int RW = clog2(NREG_DEF);

   // One bypass source as seen by the stage, sized for the default configuration
   typedef struct packed {
      logic                valid;
      logic                we;
      logic [RW-1:0]       addr;
      logic                data_ok;
      logic [XLEN_DEF-1:0] data;
   } byp_rec_t;

endpackage

// File: rtl/opstage_src_resolve.sv
// Resolves one source operand from prioritised bypass sources (index 0 wins)
// or the register-file read data; x0 and disabled sources read as zero.
module opstage_src_resolve
   import opstage_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NBYP = 3,
   localparam int AW = clog2(NREG)
) (
   input  logic [AW-1:0]        addr,
   input  logic                 en,
   input  logic [XLEN-1:0]      rf_data,
   input  logic [NBYP-1:0]      byp_valid,
   input  logic [NBYP-1:0]      byp_we,
   input  logic [NBYP*AW-1:0]   byp_addr,
   input  logic [NBYP-1:0]      byp_data_ok,
   input  logic [NBYP*XLEN-1:0] byp_data,
   output logic                 ready,
   output logic [XLEN-1:0]      value
);

   // Scan from lowest priority upward so the youngest matching source is the last writer
   always_comb begin
      ready = 1'b1;
      value = '0;
      if (en && addr != '0) begin
         value = rf_data;
         for (int i = NBYP - 1; i >= 0; i--) begin
            if (byp_valid[i] && byp_we[i] && byp_addr[i*AW +: AW] == addr) begin
               ready = byp_data_ok[i];
               value = byp_data[i*XLEN +: XLEN];
            end
         end
      end
   end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/issue stage: holds one instruction in S0, resolves its operands and registers
// them into OUT. Define OPSTAGE_STALL_CNT_EN to build the hazard-stall cycle counter.
module id_operand_stage
   import opstage_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NREG      = 32,
   parameter int NBYP      = 3,
   parameter int PAYLOAD_W = 64,
   localparam int AW = clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AW-1:0]        in_rs1,
   input  logic [AW-1:0]        in_rs2,
   input  logic                 in_rs1_en,
   input  logic                 in_rs2_en,
   input  logic [AW-1:0]        in_rd,
   input  logic                 in_rd_en,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic [AW-1:0]        rf_raddr1,
   output logic [AW-1:0]        rf_raddr2,
   input  logic [XLEN-1:0]      rf_rdata1,
   input  logic [XLEN-1:0]      rf_rdata2,
   input  logic [NBYP-1:0]      byp_valid,
   input  logic [NBYP-1:0]      byp_we,
   input  logic [NBYP*AW-1:0]   byp_addr,
   input  logic [NBYP-1:0]      byp_data_ok,
   input  logic [NBYP*XLEN-1:0] byp_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_src1,
   output logic [XLEN-1:0]      out_src2,
   output logic [AW-1:0]        out_rd,
   output logic                 out_rd_en,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [31:0]          stall_cycles
);

   logic                 s0_valid;
   logic [AW-1:0]        s0_rs1, s0_rs2, s0_rd;
   logic                 s0_rs1_en, s0_rs2_en, s0_rd_en;
   logic [PAYLOAD_W-1:0] s0_payload;
   logic                 rdy1, rdy2;
   logic [XLEN-1:0]      val1, val2;
   logic                 s0_go, accept;

   assign rf_raddr1 = s0_rs1;
   assign rf_raddr2 = s0_rs2;

   opstage_src_resolve #(.XLEN(XLEN), .NREG(NREG), .NBYP(NBYP)) u_res1 (
      .addr(s0_rs1), .en(s0_rs1_en), .rf_data(rf_rdata1),
      .byp_valid(byp_valid), .byp_we(byp_we), .byp_addr(byp_addr),
      .byp_data_ok(byp_data_ok), .byp_data(byp_data),
      .ready(rdy1), .value(val1)
   );

   opstage_src_resolve #(.XLEN(XLEN), .NREG(NREG), .NBYP(NBYP)) u_res2 (
      .addr(s0_rs2), .en(s0_rs2_en), .rf_data(rf_rdata2),
      .byp_valid(byp_valid), .byp_we(byp_we), .byp_addr(byp_addr),
      .byp_data_ok(byp_data_ok), .byp_data(byp_data),
      .ready(rdy2), .value(val2)
   );

   assign s0_go    = s0_valid & rdy1 & rdy2 & (~out_valid | out_ready);
   assign in_ready = ~s0_valid | s0_go;
   assign accept   = in_valid & in_ready;

   // Flush wins over both a new accept and the S0-to-OUT move
   always_ff @(posedge clk) begin
      if (reset) begin
         s0_valid   <= 1'b0;
         s0_rs1     <= '0;
         s0_rs2     <= '0;
         s0_rd      <= '0;
         s0_rs1_en  <= 1'b0;
         s0_rs2_en  <= 1'b0;
         s0_rd_en   <= 1'b0;
         s0_payload <= '0;
      end else begin
         if (flush)       s0_valid <= 1'b0;
         else if (accept) s0_valid <= 1'b1;
         else if (s0_go)  s0_valid <= 1'b0;
         if (accept) begin
            s0_rs1     <= in_rs1;
            s0_rs2     <= in_rs2;
            s0_rd      <= in_rd;
            s0_rs1_en  <= in_rs1_en;
            s0_rs2_en  <= in_rs2_en;
            s0_rd_en   <= in_rd_en;
            s0_payload <= in_payload;
         end
      end
   end

   // OUT only changes on a load, so fields stay put under back-pressure
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_src1    <= '0;
         out_src2    <= '0;
         out_rd      <= '0;
         out_rd_en   <= 1'b0;
         out_payload <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (s0_go) begin
         out_valid   <= 1'b1;
         out_src1    <= val1;
         out_src2    <= val2;
         out_rd      <= s0_rd;
         out_rd_en   <= s0_rd_en;
         out_payload <= s0_payload;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef OPSTAGE_STALL_CNT_EN
   logic [31:0] stall_q;

   // Counts only operand hazards, not downstream back-pressure
   always_ff @(posedge clk) begin
      if (reset)
         stall_q <= '0;
      else if (s0_valid && !(rdy1 && rdy2) && !flush)
         stall_q <= stall_q + 32'd1;
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule
